// File: rtl/transient_pulse_detector.sv
// Transient pulse detector: arms on a 10% crossing, qualifies at 90%,
// measures rise time, width and peak, then enforces a quiet holdoff.
module transient_pulse_detector #(
    parameter int DW = 12,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    input  logic [DW-1:0] baseline,
    input  logic [DW-1:0] thr_lo,
    input  logic [DW-1:0] thr_hi,
    input  logic [CW-1:0] holdoff,
    output logic          r_valid,
    input  logic          r_ready,
    output logic [CW-1:0] r_rise,
    output logic [CW-1:0] r_width,
    output logic [DW:0]   r_peak,
    output logic [CW-1:0] pulse_cnt,
    output logic [CW-1:0] runt_cnt,
    output logic          overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_HIGH,
        S_HOLD
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [DW:0]   amp;
    logic [DW-1:0] amp_mag;
    logic          amp_neg;
    logic          gt_lo;
    logic          ge_hi;
    logic [CW-1:0] rise;
    logic [CW-1:0] width;
    logic [DW:0]   peak;
    logic [CW-1:0] quiet;
    logic [CW:0]   quiet_inc;
    logic          quiet_done;
    logic          rise_max;
    logic [CW-1:0] rise_inc;
    logic [CW-1:0] width_inc;
    logic          enter_high;
    logic          pulse_end;
    logic          runt;
    logic          load_rep;

    // Sign-extended difference cannot overflow in DW+1 bits.
    assign amp     = {s_data[DW-1], s_data} - {baseline[DW-1], baseline};
    assign amp_neg = amp[DW];
    assign amp_mag = amp[DW-1:0];
    assign gt_lo   = !amp_neg && (amp_mag > thr_lo);
    assign ge_hi   = !amp_neg && (amp_mag >= thr_hi);

    assign rise_max  = &rise;
    assign rise_inc  = rise_max ? rise : rise + CW'(1);
    assign width_inc = (&width) ? width : width + CW'(1);
    assign quiet_inc = {1'b0, quiet} + (CW+1)'(1);
    assign quiet_done = (holdoff == '0) ||
                        (!gt_lo && (quiet_inc >= {1'b0, holdoff}));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state decode; only accepted samples move the machine.
    always_comb begin
        state_nx = state;
        if (s_valid) begin
            case (state)
                S_IDLE: begin
                    if (ge_hi)      state_nx = S_HIGH;
                    else if (gt_lo) state_nx = S_ARMED;
                end
                S_ARMED: begin
                    if (ge_hi)                    state_nx = S_HIGH;
                    else if (!gt_lo || rise_max)  state_nx = S_IDLE;
                end
                S_HIGH: begin
                    if (!gt_lo) state_nx = S_HOLD;
                end
                S_HOLD: begin
                    if (quiet_done) state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Transition events that drive the datapath and report channel.
    always_comb begin
        enter_high = s_valid && (state_nx == S_HIGH) && (state != S_HIGH);
        pulse_end  = s_valid && (state == S_HIGH) && !gt_lo;
        runt       = s_valid && (state == S_ARMED) && (state_nx == S_IDLE);
        load_rep   = pulse_end && (!r_valid || r_ready);
    end

    // Measurement counters, statistics and the report register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise      <= '0;
            width     <= '0;
            peak      <= '0;
            quiet     <= '0;
            r_valid   <= 1'b0;
            r_rise    <= '0;
            r_width   <= '0;
            r_peak    <= '0;
            pulse_cnt <= '0;
            runt_cnt  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (r_valid && r_ready) r_valid <= 1'b0;
            if (s_valid) begin
                case (state)
                    S_IDLE: begin
                        if (ge_hi)      rise <= '0;
                        else if (gt_lo) rise <= CW'(1);
                    end
                    S_ARMED: begin
                        if (ge_hi || (gt_lo && !rise_max)) rise <= rise_inc;
                    end
                    S_HIGH: begin
                        if (!gt_lo) quiet <= '0;
                    end
                    S_HOLD: begin
                        quiet <= gt_lo ? '0 : quiet_inc[CW-1:0];
                    end
                    default: ;
                endcase
                if (enter_high) begin
                    width <= CW'(1);
                    peak  <= amp;
                end else if ((state == S_HIGH) && gt_lo) begin
                    width <= width_inc;
                    if (amp > peak) peak <= amp;
                end
                if (pulse_end) begin
                    pulse_cnt <= pulse_cnt + CW'(1);
                    if (!load_rep) overflow <= 1'b1;
                end
                if (load_rep) begin
                    r_valid <= 1'b1;
                    r_rise  <= rise;
                    r_width <= width;
                    r_peak  <= peak;
                end
                if (runt && !(&runt_cnt)) runt_cnt <= runt_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_transient_pulse_detector.sv
// Scoreboard bench: a sample-level reference model queues expected
// reports; a negedge monitor compares whatever the DUT presents.
module tb_transient_pulse_detector;

    localparam int DW   = 12;
    localparam int CW   = 16;
    localparam int CMAX = 65535;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic [DW-1:0] baseline = '0;
    logic [DW-1:0] thr_lo = '0;
    logic [DW-1:0] thr_hi = '0;
    logic [CW-1:0] holdoff = '0;
    logic          r_valid;
    logic          r_ready = 1'b0;
    logic [CW-1:0] r_rise;
    logic [CW-1:0] r_width;
    logic [DW:0]   r_peak;
    logic [CW-1:0] pulse_cnt;
    logic [CW-1:0] runt_cnt;
    logic          overflow;

    always #5 clk = ~clk;

    transient_pulse_detector #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
        .baseline(baseline), .thr_lo(thr_lo), .thr_hi(thr_hi),
        .holdoff(holdoff), .r_valid(r_valid), .r_ready(r_ready),
        .r_rise(r_rise), .r_width(r_width), .r_peak(r_peak),
        .pulse_cnt(pulse_cnt), .runt_cnt(runt_cnt), .overflow(overflow)
    );

    typedef struct {
        int rise;
        int width;
        int peak;
    } rep_t;

    rep_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   base_i, lo_i, hi_i, ho_i;

    bit   m_arm, m_hi, m_q, m_ovf, m_rv;
    int   m_rise, m_width, m_peak, m_quiet, m_pulse, m_runt;
    bit   cur_rv, cur_ovf;
    int   cur_pulse, cur_runt;
    int   lr_rise, lr_width, lr_peak;

    int s37[11] = '{0, 30, 100, 190, 200, 150, 10, 0, 0, 0, 0};
    int s38[6]  = '{0, 50, 60, 10, 0, 0};
    int sb[9]   = '{0, 40, 250, 260, 5, 0, 0, 0, 0};
    int s41[19] = '{0, 200, 10, 0, 0, 0, 25, 0, 0, 0, 200, 5,
                    0, 0, 0, 0, 200, 5, 0};

    function void chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function void m_reset();
        m_arm = 0; m_hi = 0; m_q = 0; m_ovf = 0; m_rv = 0;
        m_rise = 0; m_width = 0; m_peak = 0; m_quiet = 0;
        m_pulse = 0; m_runt = 0;
        cur_rv = 0; cur_ovf = 0; cur_pulse = 0; cur_runt = 0;
        lr_rise = -1; lr_width = -1; lr_peak = -1;
        q.delete();
    endfunction

    // One clock of the reference: sample rules plus the report slot.
    function void m_step(bit sv, int a, bit rr);
        bit   lo, hi, nrv;
        rep_t r;
        nrv = (m_rv && rr) ? 1'b0 : m_rv;
        if (sv) begin
            lo = a > lo_i;
            hi = a >= hi_i;
            if (m_q) begin
                m_quiet = lo ? 0 : m_quiet + 1;
                if (ho_i == 0 || m_quiet >= ho_i) m_q = 0;
            end else if (m_hi) begin
                if (lo) begin
                    if (m_width < CMAX) m_width++;
                    if (a > m_peak) m_peak = a;
                end else begin
                    m_hi = 0; m_q = 1; m_quiet = 0;
                    m_pulse = (m_pulse + 1) % (CMAX + 1);
                    if (!m_rv || rr) begin
                        r = '{m_rise, m_width, m_peak};
                        q.push_back(r);
                        nrv = 1;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end else if (m_arm) begin
                if (hi) begin
                    m_arm = 0; m_hi = 1;
                    if (m_rise < CMAX) m_rise++;
                    m_width = 1; m_peak = a;
                end else if (!lo || m_rise == CMAX) begin
                    m_arm = 0;
                    if (m_runt < CMAX) m_runt++;
                end else begin
                    m_rise++;
                end
            end else begin
                if (hi) begin
                    m_hi = 1; m_rise = 0; m_width = 1; m_peak = a;
                end else if (lo) begin
                    m_arm = 1; m_rise = 1;
                end
            end
        end
        m_rv = nrv;
    endfunction

    task automatic cyc(input bit sv, input int a, input bit rr);
        s_valid = sv;
        s_data  = sv ? DW'(base_i + a) : DW'($urandom);
        r_ready = rr;
        cur_rv = m_rv; cur_ovf = m_ovf;
        cur_pulse = m_pulse; cur_runt = m_runt;
        m_step(sv, a, rr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit sv);
        rst = 1'b1;
        s_valid = sv;
        s_data = DW'(base_i + 250);
        r_ready = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        chk("rst_r_valid", int'(r_valid), 0);
        chk("rst_r_rise", int'(r_rise), 0);
        chk("rst_r_width", int'(r_width), 0);
        chk("rst_r_peak", int'(r_peak), 0);
        chk("rst_pulse_cnt", int'(pulse_cnt), 0);
        chk("rst_runt_cnt", int'(runt_cnt), 0);
        chk("rst_overflow", int'(overflow), 0);
        rst = 1'b0;
    endtask

    task automatic setup(input int b, input int lo, input int hi, input int ho);
        base_i = b; lo_i = lo; hi_i = hi; ho_i = ho;
        baseline = DW'(b);
        thr_lo = DW'(lo);
        thr_hi = DW'(hi);
        holdoff = CW'(ho);
    endtask

    // Monitor: compare presented report and counters against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            chk("r_valid", int'(r_valid), int'(cur_rv));
            chk("pulse_cnt", int'(pulse_cnt), cur_pulse);
            chk("runt_cnt", int'(runt_cnt), cur_runt);
            chk("overflow", int'(overflow), int'(cur_ovf));
            if (cur_rv) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard: report expected but queue empty");
                end else begin
                    if (r_valid) begin
                        chk("r_rise", int'(r_rise), q[0].rise);
                        chk("r_width", int'(r_width), q[0].width);
                        chk("r_peak", int'(r_peak), q[0].peak);
                    end
                    if (r_ready) begin
                        lr_rise = int'(r_rise);
                        lr_width = int'(r_width);
                        lr_peak = int'(r_peak);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int rmode;
        bit sv, rr;
        int a;

        setup(135, 20, 180, 4);
        do_reset(1'b1);

        foreach (s37[i]) cyc(1'b1, s37[i], 1'b1);
        cyc(1'b1, 0, 1'b1);
        chk("p37_rise", lr_rise, 3);
        chk("p37_width", lr_width, 3);
        chk("p37_peak", lr_peak, 200);
        chk("p37_pulse_cnt", int'(pulse_cnt), 1);

        do_reset(1'b0);
        foreach (s38[i]) cyc(1'b1, s38[i], 1'b1);
        chk("runt_cnt", int'(runt_cnt), 1);
        chk("runt_no_report", int'(r_valid), 0);
        chk("runt_pulse_cnt", int'(pulse_cnt), 0);

        do_reset(1'b1);
        foreach (s37[i]) cyc(1'b1, s37[i], 1'b0);
        foreach (sb[i]) cyc(1'b1, sb[i], 1'b0);
        chk("hold_rise", int'(r_rise), 3);
        chk("hold_width", int'(r_width), 3);
        chk("hold_peak", int'(r_peak), 200);
        chk("hold_overflow", int'(overflow), 1);
        chk("hold_pulse_cnt", int'(pulse_cnt), 2);
        for (int i = 0; i < 3; i++) cyc(1'b1, 0, 1'b1);

        do_reset(1'b0);
        foreach (s37[i]) cyc(1'b1, s37[i], 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, sb[i], 1'b0);
        cyc(1'b1, 5, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 0, 1'b1);
        chk("b2b_rise", lr_rise, 2);
        chk("b2b_width", lr_width, 2);
        chk("b2b_peak", lr_peak, 260);
        chk("b2b_overflow", int'(overflow), 0);

        do_reset(1'b1);
        foreach (s41[i]) cyc(1'b1, s41[i], 1'b1);
        chk("holdoff_pulse_cnt", int'(pulse_cnt), 2);

        do_reset(1'b0);
        foreach (s37[i]) begin
            cyc(1'b0, 0, 1'b1);
            cyc(1'b1, s37[i], 1'b1);
        end
        cyc(1'b0, 0, 1'b1);
        cyc(1'b1, 0, 1'b1);
        chk("tog_rise", lr_rise, 3);
        chk("tog_width", lr_width, 3);
        chk("tog_peak", lr_peak, 200);
        chk("tog_pulse_cnt", int'(pulse_cnt), 1);

        do_reset(1'b0);
        cyc(1'b1, 0, 1'b1);
        cyc(1'b1, 30, 1'b1);
        cyc(1'b1, 190, 1'b1);
        cyc(1'b1, 200, 1'b1);
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 0, 1'b1);

        for (int ep = 0; ep < 25; ep++) begin
            setup(int'($urandom_range(0, 800)) - 400,
                  int'($urandom_range(0, 120)),
                  int'($urandom_range(0, 250)),
                  int'($urandom_range(0, 5)));
            do_reset(1'($urandom));
            rmode = ep % 3;
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 199) == 0) begin
                    do_reset(1'($urandom));
                end else begin
                    sv = ($urandom_range(0, 3) != 0);
                    a  = int'($urandom_range(0, 320)) - 40;
                    case (rmode)
                        0:       rr = ($urandom_range(0, 7) != 0);
                        1:       rr = 1'($urandom);
                        default: rr = ($urandom_range(0, 7) == 0);
                    endcase
                    cyc(sv, a, rr);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
